// File: rtl/gate_selftest_pkg.sv
// Shared definitions for the two-input gate self-test driver: FSM encodings and
// reference truth tables indexed by {a,b}.
package gate_selftest_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // bit0 = vector 00, bit3 = vector 11
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic tt_expect(input logic [3:0] tt, input logic [1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/gate_selftest_timer.sv
// Loadable settle-time down-counter; reloads to SETTLE_CYCLES-1 and stops at zero.
module gate_selftest_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int unsigned W = $clog2(SETTLE_CYCLES) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(SETTLE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_selftest_driver.sv
// Self-test initiator for a 2-in/1-out gate: sweeps all input vectors, compares the
// sampled output against TRUTH_TABLE and reports a saturating error count and pass flag.
module gate_selftest_driver
  import gate_selftest_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_OR,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int unsigned PW = $clog2(PASSES + 1);

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             drv_a_d, drv_b_d;
  logic             busy_d, done_d, pass_d;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       fail_d;
  logic             timer_load;
  logic             timer_zero;
  logic             mismatch;

  gate_selftest_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .zero (timer_zero)
  );

  assign mismatch = (dut_y != tt_expect(TRUTH_TABLE, vec_q));

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pcnt_d     = pcnt_q;
    drv_a_d    = drv_a;
    drv_b_d    = drv_b;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    err_d      = err_count;
    fail_d     = fail_vec;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = 2'd0;
          pcnt_d     = '0;
          drv_a_d    = 1'b0;
          drv_b_d    = 1'b0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_d     = '0;
          timer_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_count != '1) begin
            err_d = err_count + ERR_W'(1);
          end
          fail_d[vec_q] = 1'b1;
        end
        if (vec_q != 2'd3) begin
          vec_d      = vec_q + 2'd1;
          {drv_a_d, drv_b_d} = vec_q + 2'd1;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end else if (pcnt_q != PW'(PASSES - 1)) begin
          pcnt_d     = pcnt_q + PW'(1);
          vec_d      = 2'd0;
          drv_a_d    = 1'b0;
          drv_b_d    = 1'b0;
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          // done/pass registered here so they are visible throughout FINISH
          state_d = ST_FINISH;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          drv_a_d = 1'b0;
          drv_b_d = 1'b0;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= 2'd0;
      pcnt_q    <= '0;
      drv_a     <= 1'b0;
      drv_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      pcnt_q    <= pcnt_d;
      drv_a     <= drv_a_d;
      drv_b     <= drv_b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fail_d;
    end
  end

endmodule

// File: doc/gate_selftest_driver.md
Name: gate_selftest_driver

Overview:
- Initiator-side companion to the two-input gate primitives: drives the A/B inputs of a device-under-test gate and samples its output.
- Walks all four input vectors, waits a programmable settle time, compares against a parameterised truth table, counts mismatches and reports pass/fail.
- Sits beside any 2-in/1-out gate instance as an on-board self-test; default truth table is OR.

Parameters:
- TRUTH_TABLE, 4'b1110, expected output indexed by {a,b}; bit0 = vector 00, bit3 = vector 11.
- SETTLE_CYCLES, 2, clocks held per vector before sampling; legal range >= 1.
- PASSES, 1, full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; honoured only in IDLE.
- drv_a  output  1  DUT input a (registered).
- drv_b  output  1  DUT input b (registered).
- dut_y  input  1  DUT output c; sampled only in SAMPLE.
- busy  output  1  high from the cycle after an accepted start through FINISH.
- done  output  1  one-cycle pulse in FINISH.
- pass  output  1  level; 1 when the last run had zero errors.
- err_count  output  ERR_W  mismatches in the last or current run; saturating.
- fail_vec  output  4  sticky per-vector mismatch flags, same index as TRUTH_TABLE.

Behaviour:
- Reset (async, any state): state=IDLE; drv_a, drv_b, busy, done and pass are 0; err_count=0; fail_vec=0; vec=0; pass counter=0.
- States: IDLE, SETTLE, SAMPLE, FINISH. Use registered outputs only; no combinational path from dut_y to any output.
- IDLE: start=1 on an edge → SETTLE.
  - Same edge: {drv_a,drv_b}=00, vec=0, pass_cnt=0, timer=SETTLE_CYCLES-1, err_count=0, fail_vec=0, pass=0.
- SETTLE: timer decrements each cycle; at timer==0 → SAMPLE. Drive values are held.
- SAMPLE: compare dut_y with TRUTH_TABLE[vec].
  - On mismatch: err_count+1 (saturates at all-ones) and fail_vec[vec]=1.
  - If vec<3: vec+1, drive {a,b}=vec+1, timer reload, → SETTLE.
  - If vec==3 and pass_cnt<PASSES-1: pass_cnt+1, vec=0, drive 00, timer reload, → SETTLE.
  - If vec==3 and pass_cnt==PASSES-1: → FINISH. The SAMPLE-cycle mismatch is included in err_count.
- FINISH: done=1 for exactly this cycle; pass=(final err_count==0); drv_a and drv_b return to 0; → IDLE.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in cycle 4*PASSES*(SETTLE_CYCLES+1)+1 after the accepting edge; with defaults, cycle 13.
- busy=1 in SETTLE, SAMPLE and FINISH; 0 in IDLE.
- start while busy (including FINISH) is ignored; no queuing.
- start held high continuously: a new run begins on the first IDLE cycle after FINISH.
- err_count, fail_vec and pass hold their values after done until the next accepted start or reset.
- Reset asserted mid-run aborts immediately with the full reset values above; no done pulse.

Decomposition:
- Shared package gate_selftest_pkg:
  - state enum/localparams: IDLE, SETTLE, SAMPLE, FINISH.
  - truth-table constants: TT_OR=4'b1110, TT_AND=4'b1000, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- One sub-module: gate_selftest_timer.
  - Loadable down-counter of width $clog2(SETTLE_CYCLES)+1.
  - Ports: load, zero flag.

Test Plan:
- Ideal OR DUT, defaults, start pulse → drive sequence 00,01,10,11, each held 3 cycles; done at cycle 13; pass=1, err_count=0, fail_vec=0000.
- DUT stuck-at-0, defaults → err_count=3, fail_vec=4'b1110, pass=0, done at cycle 13.
- NOR DUT, PASSES=3 → err_count=12, fail_vec=4'b1111, pass=0; done at cycle 37.
- Stuck-at-0 DUT, ERR_W=2, PASSES=2 → err_count saturates at 3 (not wrap to 2); pass=0.
- Ideal DUT; start re-pulsed at cycles 5 and 13 (FINISH) → both ignored; exactly one done pulse; busy falls at cycle 14.
- Ideal DUT; rst asserted asynchronously while vector 10 is driven → outputs zero immediately with no done pulse; a fresh start then completes with pass=1 at cycle 13.
